// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder and a carry flop add two WIDTH-bit operands
// LSB first, one bit per clock, behind a start/busy/done handshake.

module full_adder (
    input  logic x,
    input  logic y,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = x ^ y ^ carry_in;
    assign carry_out = (x & y) | (x & carry_in) | (y & carry_in);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic [1:0]       state_o
);
    // Handshake: start_i is taken only in IDLE or DONE (the accepting edge latches
    // a_i/b_i/cin_i); busy_o is high through RUN; done_o pulses for one cycle in DONE,
    // when sum_o/cout_o already hold the new result. start_i during RUN is dropped.

    localparam int CW_RAW = $clog2(WIDTH + 1);
    localparam int CW     = (CW_RAW < 1) ? 1 : CW_RAW;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  s_sh_q, s_sh_d;
    logic              c_q, c_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;

    logic              fa_s;
    logic              fa_c;
    logic [WIDTH-1:0]  s_next;

    full_adder u_fa (
        .x         (a_sh_q[0]),
        .y         (b_sh_q[0]),
        .carry_in  (c_q),
        .sum       (fa_s),
        .carry_out (fa_c)
    );

    // The new sum bit enters at the MSB so that after WIDTH shifts bit 0 is in place.
    if (WIDTH == 1) begin : g_s_one
        assign s_next = fa_s;
    end else begin : g_s_wide
        assign s_next = {fa_s, s_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    c_d     = cin_i;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                s_sh_d = s_next;
                c_d    = fa_c;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    sum_d   = s_next;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = (state_q == ST_DONE);
    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: queued expectations from a+b+cin, a negedge monitor that
// pops on done, plus a WIDTH=1 instance swept through the full-adder truth table.

module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start8, cin8, busy8, done8, cout8;
    logic [W-1:0] a8, b8, sum8;
    logic [1:0]   state8;
    logic         start1, a1, b1, cin1, busy1, done1, sum1, cout1;
    logic [1:0]   state1;

    serial_adder #(.WIDTH(W)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start8), .a_i(a8), .b_i(b8),
        .cin_i(cin8), .busy_o(busy8), .done_o(done8), .sum_o(sum8),
        .cout_o(cout8), .state_o(state8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start1), .a_i(a1), .b_i(b1),
        .cin_i(cin1), .busy_o(busy1), .done_o(done1), .sum_o(sum1),
        .cout_o(cout1), .state_o(state1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];
    int         cur_acc  = -1;
    logic [W:0] last_res = '0;
    bit         mon_en   = 1'b0;
    logic       m_done, m_busy;
    logic [W:0] m_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected timing: accepted at edge cur_acc, busy through the next W-1 edges,
    // done visible after edge cur_acc+W; results only change at a done.
    always @(negedge clk) begin
        if (mon_en) begin
            m_done = (cur_acc >= 0) && (cyc == cur_acc + W);
            m_busy = (cur_acc >= 0) && (cyc >= cur_acc) && (cyc < cur_acc + W);
            check("done", done8, m_done);
            check("busy", busy8, m_busy);
            if (done8) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("result", {cout8, sum8}, m_exp);
                    last_res = m_exp;
                end
            end else begin
                check("hold", {cout8, sum8}, last_res);
            end
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start8 = 1'b1;
        a8     = a;
        b8     = b;
        cin8   = c;
        @(posedge clk);
        #1;
        exp_q.push_back({1'b0, a} + {1'b0, b} + (W + 1)'(c));
        cur_acc = cyc;
        start8  = 1'b0;
        a8      = W'($urandom);
        b8      = W'($urandom);
        cin8    = 1'($urandom);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done within 40 cycles expected done (cycle %0d)", cyc);
        end
    endtask

    initial begin
        int acc1;
        bit seen1;
        logic [1:0] exp1;

        rst_n  = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_busy", busy8, 1'b0);
        check("rst_done", done8, 1'b0);
        check("rst_result", {cout8, sum8}, 9'h000);

        // Zero operands, then a full carry ripple.
        start_op(8'h00, 8'h00, 1'b0);
        wait_done();
        check("tp_zero", {cout8, sum8}, 9'h000);
        @(negedge clk);
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done();
        check("tp_ff01", {cout8, sum8}, 9'h100);
        @(negedge clk);

        // Back-to-back: second request issued in the DONE cycle.
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done();
        check("tp_a55a", {cout8, sum8}, 9'h100);
        start_op(8'h3C, 8'h42, 1'b0);
        wait_done();
        check("tp_3c42", {cout8, sum8}, 9'h07E);
        @(negedge clk);

        // start and operand changes during RUN must be ignored.
        start_op(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'hEE; b8 = 8'h77;
        wait_done();
        check("tp_ignore", {cout8, sum8}, 9'h046);
        repeat (3) @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        start_op(8'h55, 8'h66, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        cur_acc  = -1;
        exp_q.delete();
        last_res = '0;
        @(negedge clk);
        check("midrst_busy", busy8, 1'b0);
        check("midrst_result", {cout8, sum8}, 9'h000);
        repeat (12) @(negedge clk);

        // WIDTH=1 instance: full-adder truth table, done one edge after acceptance.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = i[2]; b1 = i[1]; cin1 = i[0];
            start1 = 1'b1;
            @(posedge clk);
            #1;
            acc1   = cyc;
            start1 = 1'b0;
            exp1   = 2'(i[2] + i[1] + i[0]);
            seen1  = 1'b0;
            for (int k = 0; k < 6 && !seen1; k++) begin
                @(negedge clk);
                if (done1) begin
                    seen1 = 1'b1;
                    check("w1_latency", cyc - acc1, 1);
                    check("w1_result", {cout1, sum1}, exp1);
                end
            end
            if (!seen1) begin
                checks++;
                failures++;
                $display("FAIL w1_timeout: got no done expected done for combo %0d", i);
            end
        end

        // Random sweep with a mix of back-to-back and idle gaps.
        @(negedge clk);
        for (int n = 0; n < 1000; n++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clk);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
